// File: rtl/mul64_seq.sv
// ---------------------------------------------------------------------------
// mul64_seq.sv
//
// Iterative 64x64 multiplier for the RV64M multiply group (MUL, MULH,
// MULHSU, MULHU). One 64-bit carry-lookahead adder (add64) is shared across
// every phase of the operation:
//   - sign-magnitude conversion of both operands
//   - 64 radix-2 shift-add steps
//   - two-step negation of the 128-bit product
// Latency is fixed at 68 cycles from the accept edge to out_valid.
//
// add64 ports:
//   operand1, operand2 [63:0]  addends
//   c0                         carry in
//   result [63:0]              sum
//   carry                      carry out
//
// mul64_seq ports:
//   clk, rst_n           clock (rising edge) and async active-low reset
//   in_valid / in_ready  request handshake (in_ready high only in IDLE)
//   op [1:0]             00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   operand_a/operand_b  rs1 / rs2, sampled only at the accept edge
//   flush                kills the in-flight operation
//   out_valid/out_ready  result handshake
//   result [63:0]        rd value, held stable while out_ready is low
//   busy                 high in every state other than IDLE
// ---------------------------------------------------------------------------

module add64 (
    input  logic [63:0] operand1,
    input  logic [63:0] operand2,
    input  logic        c0,
    output logic [63:0] result,
    output logic        carry
);

    logic [63:0] gen;
    logic [63:0] prop;
    logic [64:0] c;

    assign gen  = operand1 & operand2;
    assign prop = operand1 ^ operand2;

    // Carries ripple inside each 4-bit group. The carry out of a group comes
    // from its group generate/propagate terms, so the long carry path only
    // crosses one lookahead term per group.
    always_comb begin
        logic grp_g;
        logic grp_p;
        c = '0;
        c[0] = c0;
        for (int grp = 0; grp < 16; grp++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int k = 0; k < 4; k++) begin
                c[grp*4 + k + 1] = gen[grp*4 + k] | (prop[grp*4 + k] & c[grp*4 + k]);
                grp_g = gen[grp*4 + k] | (prop[grp*4 + k] & grp_g);
                grp_p = grp_p & prop[grp*4 + k];
            end
            c[grp*4 + 4] = grp_g | (grp_p & c[grp*4]);
        end
    end

    assign result = prop ^ c[63:0];
    assign carry  = c[64];

endmodule

module mul64_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [63:0] operand_a,
    input  logic [63:0] operand_b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABS_A  = 3'd1,
        ABS_B  = 3'd2,
        MUL    = 3'd3,
        NEG_LO = 3'd4,
        NEG_HI = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t      state;
    logic [63:0] hi;
    logic [63:0] lo;
    logic [63:0] mcand;
    logic        neg;
    logic        sel_hi;
    logic        cflag;
    logic [5:0]  cnt;
    logic        sa;
    logic        sb;

    logic [63:0] add_op1;
    logic [63:0] add_op2;
    logic        add_c0;
    logic [63:0] add_sum;
    logic        add_carry;

    logic        req_sa;
    logic        req_sb;

    // Operand signedness for the incoming request: rs1 is signed for MULH
    // and MULHSU, rs2 only for MULH. MUL is treated as unsigned because its
    // low half does not depend on the signedness of the operands.
    assign req_sa = ((op == 2'b01) || (op == 2'b10)) && operand_a[63];
    assign req_sb = (op == 2'b01) && operand_b[63];

    // Adder input mux. Two's-complement negation is ~x + 1, built as
    // (~x) + 0 with carry in. NEG_HI uses the NEG_LO carry instead of 1 so
    // the two halves form a single 128-bit negation.
    always_comb begin
        add_op1 = '0;
        add_op2 = '0;
        add_c0  = 1'b0;
        case (state)
            ABS_A: begin
                add_op1 = ~mcand;
                add_c0  = 1'b1;
            end
            ABS_B, NEG_LO: begin
                add_op1 = ~lo;
                add_c0  = 1'b1;
            end
            MUL: begin
                add_op1 = hi;
                add_op2 = lo[0] ? mcand : 64'd0;
            end
            NEG_HI: begin
                add_op1 = ~hi;
                add_c0  = cflag;
            end
            default: begin
                add_op1 = '0;
            end
        endcase
    end

    add64 u_add64 (
        .operand1 (add_op1),
        .operand2 (add_op2),
        .c0       (add_c0),
        .result   (add_sum),
        .carry    (add_carry)
    );

    // Main controller. flush only matters outside IDLE and overrides both
    // out_ready and the normal sequencing. The handshake outputs are
    // registered so they change on the same edges as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            neg       <= 1'b0;
            sel_hi    <= 1'b0;
            cflag     <= 1'b0;
            cnt       <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
        end else if (flush && (state != IDLE)) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= operand_a;
                        lo       <= operand_b;
                        hi       <= '0;
                        sa       <= req_sa;
                        sb       <= req_sb;
                        neg      <= req_sa ^ req_sb;
                        sel_hi   <= (op != 2'b00);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ABS_A;
                    end
                end
                ABS_A: begin
                    if (sa) begin
                        mcand <= add_sum;
                    end
                    state <= ABS_B;
                end
                ABS_B: begin
                    if (sb) begin
                        lo <= add_sum;
                    end
                    cnt   <= '0;
                    state <= MUL;
                end
                MUL: begin
                    // {hi, lo} shifts right one place; the adder carry becomes
                    // the new MSB and the multiplier bit just used drops out.
                    hi  <= {add_carry, add_sum[63:1]};
                    lo  <= {add_sum[0], lo[63:1]};
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        state <= NEG_LO;
                    end
                end
                NEG_LO: begin
                    if (neg) begin
                        lo    <= add_sum;
                        cflag <= add_carry;
                    end
                    state <= NEG_HI;
                end
                NEG_HI: begin
                    if (neg) begin
                        hi <= add_sum;
                    end
                    // Result register is loaded with the final half directly,
                    // since hi is only updated on this same edge.
                    if (sel_hi) begin
                        result <= neg ? add_sum : hi;
                    end else begin
                        result <= lo;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
